// File: rtl/crc32_stream.sv
// -----------------------------------------------------------------------------
// crc32_stream
//   Streaming Ethernet FCS engine (CRC-32, reflected poly 0xEDB88320,
//   init 0xFFFFFFFF, final inversion). Handles DATA_BYTES bytes per beat.
//
//   APPEND = 0 (CHECK):  registered pass-through of the frame, including its
//                        FCS bytes. One fcs_good or fcs_bad pulse per frame.
//   APPEND = 1 (APPEND): the frame is passed through and its 4-byte FCS is
//                        packed directly after the last data byte, LSB first.
//                        Bytes that do not fit are sent in TAIL beats.
//
// Handshake: a beat moves on a port when valid && ready are both high at a
//   rising clock edge. A source holds valid and its payload (data/keep/last)
//   stable until that happens. Ready may change freely.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   s_valid/s_ready     input beat handshake
//   s_data              input bytes, lane 0 (s_data[7:0]) first on the wire
//   s_keep              byte enables, contiguous from lane 0
//   s_last              last beat of frame
//   m_valid/m_ready     output beat handshake
//   m_data/m_keep/m_last output beat
//   fcs_good/fcs_bad    CHECK result pulses (constant 0 when APPEND = 1)
// -----------------------------------------------------------------------------
module crc32_stream #(
  parameter int DATA_BYTES = 4,
  parameter bit APPEND     = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [8*DATA_BYTES-1:0] m_data,
  output logic [DATA_BYTES-1:0]   m_keep,
  output logic                    m_last,
  output logic                    fcs_good,
  output logic                    fcs_bad
);

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  // ~crc over a frame that ends in its own correct FCS.
  localparam logic [31:0] RESIDUE = 32'h2144DF1C;

  localparam logic [0:0] ST_STREAM = 1'b0;
  localparam logic [0:0] ST_TAIL   = 1'b1;

  // One byte of the table-driven update: (crc >> 8) ^ T[crc[7:0] ^ b].
  // The table entry is generated by eight shift/xor steps.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  // State
  logic [0:0]  state;
  logic [31:0] crc_q;
  logic [2:0]  runt_cnt;
  logic [31:0] tail_fcs;   // FCS bytes still owed, next one in [7:0]
  logic [2:0]  tail_rem;   // number of FCS bytes still owed (1..4 in TAIL)

  logic load_ok;
  logic s_hs;

  assign load_ok = ~m_valid | m_ready;
  assign s_ready = load_ok && (state == ST_STREAM);
  assign s_hs    = s_valid && s_ready;

  // CRC fold over the kept lanes of the current beat
  logic [31:0] crc_next;
  logic [31:0] fcs_val;
  logic [3:0]  n_kept;
  logic [3:0]  free_n;
  logic [3:0]  cnt_sum;
  logic [2:0]  cnt_next;

  always_comb begin
    crc_next = crc_q;
    n_kept   = 4'd0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (s_keep[i]) begin
        crc_next = crc_byte(crc_next, s_data[8*i +: 8]);
        n_kept   = n_kept + 4'd1;
      end
    end
  end

  assign fcs_val  = ~crc_next;
  assign free_n   = 4'(DATA_BYTES) - n_kept;
  assign cnt_sum  = {1'b0, runt_cnt} + n_kept;
  assign cnt_next = (cnt_sum >= 4'd4) ? 3'd4 : cnt_sum[2:0];

  // APPEND: last beat with the first FCS bytes packed into the free lanes
  logic [8*DATA_BYTES-1:0] app_data;
  logic [DATA_BYTES-1:0]   app_keep;
  logic                    app_last;
  logic [2:0]              app_rem;
  logic [31:0]             app_tail_fcs;

  always_comb begin
    app_data     = '0;
    app_keep     = '0;
    app_last     = 1'b1;
    app_rem      = 3'd0;
    app_tail_fcs = 32'h0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (i < int'(n_kept)) begin
        app_data[8*i +: 8] = s_data[8*i +: 8];
        app_keep[i]        = 1'b1;
      end else if (i - int'(n_kept) < 4) begin
        app_data[8*i +: 8] = 8'(fcs_val >> (8 * (i - int'(n_kept))));
        app_keep[i]        = 1'b1;
      end
    end
    if (free_n < 4'd4) begin
      app_last     = 1'b0;
      app_rem      = 3'(4'd4 - free_n);
      app_tail_fcs = fcs_val >> {free_n, 3'b000};
    end
  end

  // APPEND: TAIL beat, remaining FCS bytes from lane 0
  logic [8*DATA_BYTES-1:0] tail_data;
  logic [DATA_BYTES-1:0]   tail_keep;
  logic [2:0]              tail_rem_after;
  int                      tail_take;

  always_comb begin
    tail_data = '0;
    tail_keep = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (i < int'(tail_rem)) begin
        tail_data[8*i +: 8] = 8'(tail_fcs >> (8 * i));
        tail_keep[i]        = 1'b1;
      end
    end
    tail_take      = (int'(tail_rem) > DATA_BYTES) ? DATA_BYTES : int'(tail_rem);
    tail_rem_after = 3'(int'(tail_rem) - tail_take);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_STREAM;
      crc_q    <= CRC_INIT;
      runt_cnt <= 3'd0;
      tail_fcs <= 32'h0;
      tail_rem <= 3'd0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_keep   <= '0;
      m_last   <= 1'b0;
      fcs_good <= 1'b0;
      fcs_bad  <= 1'b0;
    end else begin
      fcs_good <= 1'b0;
      fcs_bad  <= 1'b0;

      // A last beat reloads the init value so the next frame can follow
      // back-to-back and fold from 0xFFFFFFFF.
      if (s_hs) begin
        crc_q    <= s_last ? CRC_INIT : crc_next;
        runt_cnt <= s_last ? 3'd0 : cnt_next;
      end

      if (!APPEND && s_hs && s_last) begin
        if (fcs_val == RESIDUE && cnt_next >= 3'd4) fcs_good <= 1'b1;
        else                                        fcs_bad  <= 1'b1;
      end

      if (load_ok) begin
        if (state == ST_TAIL) begin
          m_valid  <= 1'b1;
          m_data   <= tail_data;
          m_keep   <= tail_keep;
          m_last   <= (tail_rem_after == 3'd0);
          tail_fcs <= tail_fcs >> (8 * DATA_BYTES);
          tail_rem <= tail_rem_after;
          if (tail_rem_after == 3'd0) state <= ST_STREAM;
        end else begin
          m_valid <= s_valid;
          if (s_valid) begin
            if (APPEND && s_last) begin
              m_data <= app_data;
              m_keep <= app_keep;
              m_last <= app_last;
              if (!app_last) begin
                state    <= ST_TAIL;
                tail_rem <= app_rem;
                tail_fcs <= app_tail_fcs;
              end
            end else begin
              m_data <= s_data;
              m_keep <= s_keep;
              m_last <= s_last;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_crc32_stream.sv
// -----------------------------------------------------------------------------
// tb_crc32_stream
//   Eight crc32_stream instances: DATA_BYTES 1/2/4/8 in CHECK (index 0..3)
//   and in APPEND (index 4..7). One instance is active at a time; a single
//   monitor follows the active one. Expected output bytes and status pulses
//   come from a byte-level reference (bitwise CRC-32 over byte queues).
// -----------------------------------------------------------------------------
module tb_crc32_stream;

  localparam int NI = 8;
  localparam int W  = 9;   // {last, byte}

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        s_valid_a [NI];
  logic        s_last_a  [NI];
  logic [63:0] s_data_a  [NI];
  logic [7:0]  s_keep_a  [NI];
  logic        m_ready_a [NI] = '{default: 1'b1};
  logic        s_ready_a [NI];
  logic        m_valid_a [NI];
  logic        m_last_a  [NI];
  logic        fcs_good_a[NI];
  logic        fcs_bad_a [NI];
  logic [63:0] m_data_a  [NI];
  logic [7:0]  m_keep_a  [NI];

  int n_tests = 0;
  int n_fail  = 0;
  int active  = 0;
  int ready_pct = 100;
  bit mon_data_en = 1'b1;

  logic [W-1:0] exp_q[$];
  logic         stat_q[$];

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int DB  = 1 << (g % 4);
    localparam bit APP = (g >= 4);
    logic [8*DB-1:0] md;
    logic [DB-1:0]   mk;
    crc32_stream #(.DATA_BYTES(DB), .APPEND(APP)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .s_valid  (s_valid_a[g]),
      .s_ready  (s_ready_a[g]),
      .s_data   (s_data_a[g][8*DB-1:0]),
      .s_keep   (s_keep_a[g][DB-1:0]),
      .s_last   (s_last_a[g]),
      .m_valid  (m_valid_a[g]),
      .m_ready  (m_ready_a[g]),
      .m_data   (md),
      .m_keep   (mk),
      .m_last   (m_last_a[g]),
      .fcs_good (fcs_good_a[g]),
      .fcs_bad  (fcs_bad_a[g])
    );
    assign m_data_a[g] = 64'(md);
    assign m_keep_a[g] = 8'(mk);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [31:0] ref_fcs(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      repeat (8) c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'h0);
    end
    return ~c;
  endfunction

  task automatic expect_raw(input logic [7:0] q[$]);
    for (int i = 0; i < q.size(); i++) exp_q.push_back({i == q.size() - 1, q[i]});
  endtask

  // stat < 0: status derived from the model; otherwise forced to stat[0]
  task automatic expect_frame(input int g, input logic [7:0] fb[$], input int stat);
    logic [7:0]  all[$];
    logic [7:0]  pay[$];
    logic [31:0] f;
    int n;
    n = fb.size();
    all = fb;
    if (g >= 4) begin
      f = ref_fcs(fb);
      for (int k = 0; k < 4; k++) all.push_back(f[8*k +: 8]);
    end
    expect_raw(all);
    if (g < 4) begin
      if (stat >= 0) stat_q.push_back(stat[0]);
      else if (n < 4) stat_q.push_back(1'b0);
      else begin
        for (int i = 0; i < n - 4; i++) pay.push_back(fb[i]);
        stat_q.push_back(ref_fcs(pay) == {fb[n-1], fb[n-2], fb[n-3], fb[n-4]});
      end
    end
  endtask

  task automatic make_frame(input int g, input int len, output logic [7:0] fb[$]);
    logic [31:0] f;
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    // CHECK frames: about half carry a correct FCS
    if (g < 4 && $urandom_range(1) == 1) begin
      f = ref_fcs(fb);
      for (int k = 0; k < 4; k++) fb.push_back(f[8*k +: 8]);
    end
  endtask

  // driver: inputs change 1 time unit after the rising edge
  task automatic send_frame(input int g, input logic [7:0] fb[$], input bit do_last, input int gap_pct);
    int db, n, pos, guard;
    bit hs;
    logic [63:0] d;
    logic [7:0]  k;
    db = 1 << (g % 4);
    n = fb.size();
    pos = 0;
    while (pos < n) begin
      if ($urandom_range(99) < gap_pct) begin
        s_valid_a[g] = 1'b0;
        @(posedge clk); #1;
        continue;
      end
      d = {$urandom, $urandom};
      k = 8'h0;
      for (int i = 0; i < db; i++) begin
        if (pos + i < n) begin
          d[8*i +: 8] = fb[pos+i];
          k[i] = 1'b1;
        end
      end
      s_data_a[g]  = d;
      s_keep_a[g]  = k;
      s_last_a[g]  = do_last && (pos + db >= n);
      s_valid_a[g] = 1'b1;
      hs = 1'b0;
      guard = 0;
      while (!hs) begin
        @(negedge clk);
        hs = s_ready_a[g];
        @(posedge clk); #1;
        guard++;
        if (!hs && guard > 2000) begin
          check("s_ready_timeout", 64'(hs), 64'd1);
          s_valid_a[g] = 1'b0;
          return;
        end
      end
      pos += db;
    end
    s_valid_a[g] = 1'b0;
    s_last_a[g]  = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || stat_q.size() != 0) && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_bytes_left", 64'(exp_q.size()), 64'd0);
    check("drain_status_left", 64'(stat_q.size()), 64'd0);
  endtask

  // m_ready: random per cycle, at the same phase as the driver
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < NI; g++) m_ready_a[g] = ($urandom_range(99) < ready_pct);
  end

  // scoreboard / monitor, sampled on the falling edge
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [8:0]  prev_kl;
  int          prev_a = -1;

  always @(negedge clk) begin
    int a, db, hi;
    logic [W-1:0] act, e;
    logic est;
    a = active;
    db = 1 << (a % 4);
    if (reset || a != prev_a) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 64'(m_valid_a[a]), 64'd1);
        check("stall_data_held", m_data_a[a], prev_data);
        check("stall_keep_last_held", 64'({m_keep_a[a], m_last_a[a]}), 64'(prev_kl));
      end
      prev_stall = m_valid_a[a] && !m_ready_a[a];
      prev_data  = m_data_a[a];
      prev_kl    = {m_keep_a[a], m_last_a[a]};

      if (m_valid_a[a] && m_ready_a[a] && mon_data_en) begin
        hi = -1;
        for (int i = 0; i < db; i++) if (m_keep_a[a][i]) hi = i;
        for (int i = 0; i < db; i++) begin
          if (m_keep_a[a][i]) begin
            act = {m_last_a[a] && (i == hi), m_data_a[a][8*i +: 8]};
            check("byte_was_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("out_byte_last", 64'(act), 64'(e));
            end
          end
        end
      end

      if (fcs_good_a[a] || fcs_bad_a[a]) begin
        if (a >= 4) begin
          check("append_status_tied0", 64'({fcs_good_a[a], fcs_bad_a[a]}), 64'd0);
        end else begin
          check("status_one_hot", 64'(fcs_good_a[a] & fcs_bad_a[a]), 64'd0);
          check("status_was_expected", 64'(stat_q.size() != 0), 64'd1);
          if (stat_q.size() != 0) begin
            est = stat_q.pop_front();
            check("status_good", 64'(fcs_good_a[a]), 64'(est));
          end
        end
      end
    end
    prev_a = a;
  end

  // main sequence
  initial begin
    logic [7:0] q1[$];
    logic [7:0] q[$];
    int len;

    for (int g = 0; g < NI; g++) begin
      s_valid_a[g] = 1'b0;
      s_last_a[g]  = 1'b0;
      s_data_a[g]  = 64'h0;
      s_keep_a[g]  = 8'h0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("reset_outputs_zero",
            64'({m_valid_a[g], m_last_a[g], fcs_good_a[g], fcs_bad_a[g], m_keep_a[g]}), 64'd0);
      check("reset_m_data_zero", m_data_a[g], 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) check("reset_s_ready", 64'(s_ready_a[g]), 64'd1);
    @(posedge clk); #1;

    // Test 1: CHECK, 1 byte/beat, "123456789" + correct FCS
    active = 0;
    ready_pct = 100;
    q1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    expect_frame(0, q1, 1);
    send_frame(0, q1, 1'b1, 0);
    @(negedge clk);
    check("t1_good_after_last", 64'(fcs_good_a[0]), 64'd1);
    drain();

    // Test 2: same frame with a bit flip in byte 5
    q = q1;
    q[4] = 8'h34;
    expect_frame(0, q, 0);
    send_frame(0, q, 1'b1, 0);
    @(negedge clk);
    check("t2_bad_after_last", 64'({fcs_good_a[0], fcs_bad_a[0]}), 64'b01);
    drain();

    // Test 3: APPEND, 4 bytes/beat, "123456789" -> FCS packed behind data
    active = 6;
    q = q1[0:8];
    expect_raw(q1);
    send_frame(6, q, 1'b1, 0);
    drain();

    // Test 4: APPEND, 8-byte frame, FCS needs a full TAIL beat
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    expect_frame(6, q, -1);
    send_frame(6, q, 1'b1, 0);
    @(negedge clk);
    check("t4_tail_blocks_input", 64'(s_ready_a[6]), 64'd0);
    drain();

    // Test 6: runt, then reset mid-frame, then a clean frame
    active = 0;
    q = '{8'h31, 8'h32, 8'h33};
    expect_frame(0, q, 0);
    send_frame(0, q, 1'b1, 0);
    drain();
    mon_data_en = 1'b0;
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    send_frame(0, q, 1'b0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mon_data_en = 1'b1;
    expect_frame(0, q1, 1);
    send_frame(0, q1, 1'b1, 0);
    drain();

    // Test 5: random frames with gaps and backpressure, every instance
    ready_pct = 60;
    for (int g = 0; g < NI; g++) begin
      active = g;
      @(posedge clk); #1;
      for (int f = 0; f < 6; f++) begin
        len = (f == 0) ? $urandom_range(1000, 1514) : $urandom_range(1, 70);
        make_frame(g, len, q);
        expect_frame(g, q, -1);
        send_frame(g, q, 1'b1, 30);
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
